// File: rtl/stream_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// stream_pkt_arbiter
//   Packet-aware round-robin arbiter that shares one AXI-stream-style output
//   among N_PORTS requester streams. A grant covers a whole packet. It is
//   released on TLAST, on an idle-gap timeout when another port is waiting,
//   or when a packet runs to MAX_PKT_BEATS beats without TLAST.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   s_tvalid/s_tdata    per-port stream inputs (port k = s_tdata[k*DW +: DW])
//   s_tready            per-port accept; only the granted port can be high
//   s_arb_req_suppress  per-port block on new grants (an active grant is kept)
//   m_tvalid/m_tdata    shared output stream, TLAST carried in m_tdata[TLAST_BIT]
//   m_tready            downstream accept
//   grant               one-hot registered grant, zero when idle
//   timeout_count       saturating count of idle-timeout releases
//   overrun_count       saturating count of MAX_PKT_BEATS releases
// ----------------------------------------------------------------------------
module stream_pkt_arbiter #(
    parameter int unsigned N_PORTS            = 4,
    parameter int unsigned DW                 = 32,
    parameter int unsigned TLAST_BIT          = DW - 1,
    parameter bit          PACKET_MODE        = 1'b1,
    parameter int unsigned IDLE_CYCLE_TIMEOUT = 10,
    parameter int unsigned MAX_PKT_BEATS      = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [N_PORTS-1:0]    s_tvalid,
    input  logic [N_PORTS*DW-1:0] s_tdata,
    output logic [N_PORTS-1:0]    s_tready,
    input  logic [N_PORTS-1:0]    s_arb_req_suppress,
    output logic                  m_tvalid,
    output logic [DW-1:0]         m_tdata,
    input  logic                  m_tready,
    output logic [N_PORTS-1:0]    grant,
    output logic [15:0]           timeout_count,
    output logic [15:0]           overrun_count
);

    localparam int unsigned PW = $clog2(N_PORTS);
    localparam int unsigned BW = $clog2(MAX_PKT_BEATS + 1);
    localparam int unsigned IW = $clog2(IDLE_CYCLE_TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               state_q;
    logic [N_PORTS-1:0]   grant_q;
    logic [PW-1:0]        last_port_q;
    logic [BW-1:0]        beat_cnt_q;
    logic [IW-1:0]        idle_cnt_q;
    logic [15:0]          timeout_cnt_q;
    logic [15:0]          overrun_cnt_q;

    logic [N_PORTS-1:0]   req;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic                 beat;
    logic                 tlast;
    logic                 other_req;

    // Combinational datapath from the granted port; grant_q is zero in IDLE,
    // which keeps m_tvalid, m_tdata and s_tready at zero there.
    always_comb begin
        m_tvalid = |(s_tvalid & grant_q);
        m_tdata  = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (grant_q[k]) begin
                m_tdata = m_tdata | s_tdata[k*DW +: DW];
            end
        end
        s_tready = grant_q & {N_PORTS{m_tready}};
    end

    assign req       = s_tvalid & ~s_arb_req_suppress;
    assign beat      = m_tvalid & m_tready;
    assign tlast     = m_tdata[TLAST_BIT];
    assign other_req = |(req & ~grant_q);

    // Rotating scan starting just after the last served port, so the port
    // served most recently is the last one considered.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            int unsigned idx;
            idx = 32'(last_port_q) + i;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_port_q   <= PW'(N_PORTS - 1);
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            overrun_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q     <= ST_BUSY;
                        grant_q     <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick_idx;
                        last_port_q <= pick_idx;
                        beat_cnt_q  <= '0;
                        idle_cnt_q  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (beat && (tlast || !PACKET_MODE)) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end else if (beat) begin
                        idle_cnt_q <= '0;
                        // Runaway packet: the tail resumes later under a fresh grant.
                        if (beat_cnt_q + BW'(1) == BW'(MAX_PKT_BEATS)) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            if (overrun_cnt_q != 16'hFFFF) begin
                                overrun_cnt_q <= overrun_cnt_q + 16'd1;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end else if (m_tvalid) begin
                        // Back-pressure: source is ready to send, never an idle gap.
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IW'(IDLE_CYCLE_TIMEOUT)) begin
                        // Only give the bus away when someone else is waiting.
                        if (other_req) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            if (timeout_cnt_q != 16'hFFFF) begin
                                timeout_cnt_q <= timeout_cnt_q + 16'd1;
                            end
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign timeout_count = timeout_cnt_q;
    assign overrun_count = overrun_cnt_q;

endmodule
